// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready
// requesters and buffers each port's result in a one-entry response register.
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int FN_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_req0_valid,
    output logic            io_req0_ready,
    input  logic [FN_W-1:0] io_req0_fn,
    input  logic [XLEN-1:0] io_req0_in1,
    input  logic [XLEN-1:0] io_req0_in2,
    input  logic            io_req1_valid,
    output logic            io_req1_ready,
    input  logic [FN_W-1:0] io_req1_fn,
    input  logic [XLEN-1:0] io_req1_in1,
    input  logic [XLEN-1:0] io_req1_in2,
    output logic            io_resp0_valid,
    input  logic            io_resp0_ready,
    output logic [XLEN-1:0] io_resp0_out,
    output logic [XLEN-1:0] io_resp0_adder_out,
    output logic            io_resp1_valid,
    input  logic            io_resp1_ready,
    output logic [XLEN-1:0] io_resp1_out,
    output logic [XLEN-1:0] io_resp1_adder_out,
    output logic [FN_W-1:0] io_alu_fn,
    output logic [XLEN-1:0] io_alu_in1,
    output logic [XLEN-1:0] io_alu_in2,
    input  logic [XLEN-1:0] io_alu_out,
    input  logic [XLEN-1:0] io_alu_adder_out
);

    logic            last_grant;
    logic            resp0_valid;
    logic            resp1_valid;
    logic [XLEN-1:0] resp0_out;
    logic [XLEN-1:0] resp0_adder_out;
    logic [XLEN-1:0] resp1_out;
    logic [XLEN-1:0] resp1_adder_out;

    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    // A full buffer being drained this cycle is free to take a new result.
    assign elig0 = io_req0_valid & (~resp0_valid | io_resp0_ready);
    assign elig1 = io_req1_valid & (~resp1_valid | io_resp1_ready);

    // On a tie the port that did not win last time gets the ALU.
    assign grant0 = elig0 & (~elig1 | last_grant);
    assign grant1 = elig1 & (~elig0 | ~last_grant);

    assign io_req0_ready = grant0;
    assign io_req1_ready = grant1;

    always_comb begin
        io_alu_fn  = '0;
        io_alu_in1 = '0;
        io_alu_in2 = '0;
        if (grant0) begin
            io_alu_fn  = io_req0_fn;
            io_alu_in1 = io_req0_in1;
            io_alu_in2 = io_req0_in2;
        end else if (grant1) begin
            io_alu_fn  = io_req1_fn;
            io_alu_in1 = io_req1_in1;
            io_alu_in2 = io_req1_in2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant      <= 1'b1;
            resp0_valid     <= 1'b0;
            resp1_valid     <= 1'b0;
            resp0_out       <= '0;
            resp0_adder_out <= '0;
            resp1_out       <= '0;
            resp1_adder_out <= '0;
        end else begin
            if (grant0) begin
                resp0_valid     <= 1'b1;
                resp0_out       <= io_alu_out;
                resp0_adder_out <= io_alu_adder_out;
                last_grant      <= 1'b0;
            end else if (io_resp0_ready) begin
                resp0_valid <= 1'b0;
            end

            if (grant1) begin
                resp1_valid     <= 1'b1;
                resp1_out       <= io_alu_out;
                resp1_adder_out <= io_alu_adder_out;
                last_grant      <= 1'b1;
            end else if (io_resp1_ready) begin
                resp1_valid <= 1'b0;
            end
        end
    end

    assign io_resp0_valid     = resp0_valid;
    assign io_resp0_out       = resp0_out;
    assign io_resp0_adder_out = resp0_adder_out;
    assign io_resp1_valid     = resp1_valid;
    assign io_resp1_out       = resp1_out;
    assign io_resp1_adder_out = resp1_adder_out;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small ALU model drives the DUT's ALU port, a
// transaction-level model predicts grants and a scoreboard checks responses.
module tb_alu_arbiter;

    localparam int XLEN = 32;
    localparam int FN_W = 4;

    typedef struct packed {
        logic [XLEN-1:0] out;
        logic [XLEN-1:0] adder_out;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            io_req0_valid, io_req1_valid;
    logic            io_req0_ready, io_req1_ready;
    logic [FN_W-1:0] io_req0_fn, io_req1_fn;
    logic [XLEN-1:0] io_req0_in1, io_req0_in2, io_req1_in1, io_req1_in2;
    logic            io_resp0_valid, io_resp1_valid;
    logic            io_resp0_ready, io_resp1_ready;
    logic [XLEN-1:0] io_resp0_out, io_resp0_adder_out;
    logic [XLEN-1:0] io_resp1_out, io_resp1_adder_out;
    logic [FN_W-1:0] io_alu_fn;
    logic [XLEN-1:0] io_alu_in1, io_alu_in2;
    logic [XLEN-1:0] io_alu_out, io_alu_adder_out;

    int   compared   = 0;
    int   mismatched = 0;
    bit   mon_en     = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    int   model_last;
    int   grant_count0;
    int   grant_count1;

    always #5 clock = ~clock;

    alu_arbiter #(.XLEN(XLEN), .FN_W(FN_W)) dut (
        .clock(clock), .reset(reset),
        .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready),
        .io_req0_fn(io_req0_fn), .io_req0_in1(io_req0_in1), .io_req0_in2(io_req0_in2),
        .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready),
        .io_req1_fn(io_req1_fn), .io_req1_in1(io_req1_in1), .io_req1_in2(io_req1_in2),
        .io_resp0_valid(io_resp0_valid), .io_resp0_ready(io_resp0_ready),
        .io_resp0_out(io_resp0_out), .io_resp0_adder_out(io_resp0_adder_out),
        .io_resp1_valid(io_resp1_valid), .io_resp1_ready(io_resp1_ready),
        .io_resp1_out(io_resp1_out), .io_resp1_adder_out(io_resp1_adder_out),
        .io_alu_fn(io_alu_fn), .io_alu_in1(io_alu_in1), .io_alu_in2(io_alu_in2),
        .io_alu_out(io_alu_out), .io_alu_adder_out(io_alu_adder_out)
    );

    // Stand-in ALU: fn 0 add, 1 sll, 5 srl, 4 xor, 6 or, 7 and, 10 sub, 11 sra.
    function automatic logic [XLEN-1:0] alu_out_fn(input logic [FN_W-1:0] fn,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        case (fn)
            4'd1:    return a << b[4:0];
            4'd4:    return a ^ b;
            4'd5:    return a >> b[4:0];
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd10:   return a - b;
            4'd11:   return $signed(a) >>> b[4:0];
            default: return a + b;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_adder_fn(input logic [FN_W-1:0] fn,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
        return (fn == 4'd10) ? a - b : a + b;
    endfunction

    assign io_alu_out       = alu_out_fn(io_alu_fn, io_alu_in1, io_alu_in2);
    assign io_alu_adder_out = alu_adder_fn(io_alu_fn, io_alu_in1, io_alu_in2);

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the predicted
    // grant and ALU drive, then advance the reference model at the rising edge.
    task automatic applyStimulus(input bit rst,
                                 input bit v0, input logic [FN_W-1:0] f0,
                                 input logic [XLEN-1:0] a0, input logic [XLEN-1:0] b0,
                                 input bit v1, input logic [FN_W-1:0] f1,
                                 input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1,
                                 input bit rr0, input bit rr1);
        bit e0, e1;
        int win;
        @(negedge clock);
        reset = rst;
        io_req0_valid = v0; io_req0_fn = f0; io_req0_in1 = a0; io_req0_in2 = b0;
        io_req1_valid = v1; io_req1_fn = f1; io_req1_in1 = a1; io_req1_in2 = b1;
        io_resp0_ready = rr0; io_resp1_ready = rr1;
        #1;
        e0 = v0 && (q0.size() == 0 || rr0);
        e1 = v1 && (q1.size() == 0 || rr1);
        if (e0 && e1)  win = (model_last == 0) ? 1 : 0;
        else if (e0)   win = 0;
        else if (e1)   win = 1;
        else           win = -1;
        checkOutput("req0_ready", {31'b0, io_req0_ready}, {31'b0, win == 0});
        checkOutput("req1_ready", {31'b0, io_req1_ready}, {31'b0, win == 1});
        checkOutput("alu_fn",  {28'b0, io_alu_fn}, (win == 0) ? {28'b0, f0} : (win == 1) ? {28'b0, f1} : '0);
        checkOutput("alu_in1", io_alu_in1, (win == 0) ? a0 : (win == 1) ? a1 : '0);
        checkOutput("alu_in2", io_alu_in2, (win == 0) ? b0 : (win == 1) ? b1 : '0);
        if (io_req0_ready) grant_count0++;
        if (io_req1_ready) grant_count1++;
        @(posedge clock);
        if (rst) begin
            q0.delete();
            q1.delete();
            model_last = 1;
        end else if (win == 0) begin
            q0.push_back('{alu_out_fn(f0, a0, b0), alu_adder_fn(f0, a0, b0)});
            model_last = 0;
        end else if (win == 1) begin
            q1.push_back('{alu_out_fn(f1, a1, b1), alu_adder_fn(f1, a1, b1)});
            model_last = 1;
        end
    endtask

    task automatic idleCycle(input bit rr0, input bit rr1);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, rr0, rr1);
    endtask

    // Monitor: compares buffered responses with the scoreboard each cycle and
    // retires an entry when the port consumes it.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (mon_en) begin
                checkOutput("resp0_valid", {31'b0, io_resp0_valid}, {31'b0, q0.size() != 0});
                checkOutput("resp1_valid", {31'b0, io_resp1_valid}, {31'b0, q1.size() != 0});
                if (q0.size() != 0) begin
                    checkOutput("resp0_out", io_resp0_out, q0[0].out);
                    checkOutput("resp0_adder_out", io_resp0_adder_out, q0[0].adder_out);
                    if (io_resp0_ready) void'(q0.pop_front());
                end
                if (q1.size() != 0) begin
                    checkOutput("resp1_out", io_resp1_out, q1[0].out);
                    checkOutput("resp1_adder_out", io_resp1_adder_out, q1[0].adder_out);
                    if (io_resp1_ready) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        model_last = 1;
        reset = 1'b1;
        io_req0_valid = 1'b0; io_req1_valid = 1'b0;
        io_req0_fn = '0; io_req0_in1 = '0; io_req0_in2 = '0;
        io_req1_fn = '0; io_req1_in1 = '0; io_req1_in2 = '0;
        io_resp0_ready = 1'b0; io_resp1_ready = 1'b0;
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;

        // Single request from port 0 returns 5+7 one cycle later.
        applyStimulus(1'b0, 1, 4'd0, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t1_resp0_valid", {31'b0, io_resp0_valid}, 32'd1);
        checkOutput("t1_resp0_out", io_resp0_out, 32'd12);

        // Port 0 buffer full and not drained: port 1 takes every grant.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1, 4'd4, 32'hA5, 32'h3C, 1, 4'd1, i, 32'd1, 0, 1);
        #2;
        checkOutput("t4_resp0_hold", io_resp0_out, 32'd12);
        applyStimulus(1'b0, 1, 4'd6, 32'hF0, 32'h0F, 1, 4'd0, 32'd3, 32'd4, 1, 1);
        #2;
        checkOutput("t4_resp0_new", io_resp0_out, 32'hFF);

        // Tie straight after reset: port 0 first, then port 1.
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1'b0, 1, 4'd10, 32'd20, 32'd7, 1, 4'd1, 32'd20, 32'd2, 1, 1);
        #2;
        checkOutput("t2_resp0_out", io_resp0_out, 32'd13);
        applyStimulus(1'b0, 0, 4'd0, 0, 0, 1, 4'd1, 32'd20, 32'd2, 1, 1);
        #2;
        checkOutput("t2_resp1_out", io_resp1_out, 32'd80);

        // Continuous contention splits eight cycles evenly.
        grant_count0 = 0;
        grant_count1 = 0;
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1, 4'd7, i, 32'hFF, 1, 4'd5, 32'h800 + i, 32'd2, 1, 1);
        checkOutput("t3_grants0", grant_count0, 32'd4);
        checkOutput("t3_grants1", grant_count1, 32'd4);

        // Idle cycle leaves the ALU inputs at zero.
        idleCycle(1'b1, 1'b1);
        idleCycle(1'b1, 1'b1);

        // Reset while port 0 holds a result and port 1 is waiting.
        applyStimulus(1'b0, 1, 4'd0, 32'd1, 32'd2, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 0, 1, 4'd0, 32'd9, 32'd9, 0, 0);
        #2;
        checkOutput("t6_resp0_valid", {31'b0, io_resp0_valid}, 32'd0);
        checkOutput("t6_resp1_valid", {31'b0, io_resp1_valid}, 32'd0);
        grant_count0 = 0;
        applyStimulus(1'b0, 1, 4'd0, 32'd1, 32'd1, 1, 4'd0, 32'd2, 32'd2, 1, 1);
        checkOutput("t6_first_tie_p0", grant_count0, 32'd1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 9) < 7, 4'($urandom), $urandom, $urandom,
                          $urandom_range(0, 9) < 7, 4'($urandom), $urandom, $urandom,
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
        end
        idleCycle(1'b1, 1'b1);
        idleCycle(1'b1, 1'b1);

        @(negedge clock);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
